strip_mem_arbiter: RTL
======================

// Module: strip_mem_arbiter
// PURPOSE
//  Shares the single BRAM read port among NUM_PORTS strip drivers. Each driver raises a
//  level request with an address; the arbiter grants one port per cycle in round-robin
//  order, issues the BRAM read, and returns data with a one-cycle ready pulse to the owner.
//  Sits between the strip_driver instances and the frame BRAM read port; SPI writes use
//  the independent write port and are not arbitrated here.
// PARAMETERS
//  NUM_PORTS      8   number of requesters (>=2)
//  ADDRESS_WIDTH  13  BRAM address width
//  DATA_WIDTH     8   BRAM data width
// PORTS
//  clk        in   1                      single clock; all logic on posedge
//  rst        in   1                      asynchronous, active-high reset
//  req        in   NUM_PORTS              per-port level request; bit i = port i
//  addr       in   NUM_PORTS*ADDRESS_WIDTH flattened; port i at [i*AW +: AW]
//  rdata      out  DATA_WIDTH             shared return data, valid when any rdy bit high
//  rdy        out  NUM_PORTS              one-hot, one-cycle pulse: rdata belongs to port i
//  mem_ren    out  1                      BRAM read enable
//  mem_raddr  out  ADDRESS_WIDTH          BRAM read address
//  mem_rdata  in   DATA_WIDTH             BRAM read data, valid 1 cycle after raddr sampled
//  busy       out  1                      high while any read is in flight
// BEHAVIOUR
//  - Reset: rdy=0, rdata=0, mem_ren=0, mem_raddr=0, busy=0, in-flight mask=0,
//    last-grant pointer=NUM_PORTS-1 (so port 0 wins first).
//  - Requester contract: hold req and addr stable until its rdy pulse; may drop req in
//    the rdy cycle. req still high the cycle after rdy = new request (new addr by then).
//  - Eligible(i) = req[i] & !inflight[i]. One grant per cycle max.
//  - Grant: search from (last+1) mod NUM_PORTS upward, first eligible wins; pointer <=g.
//  - Pipeline (grant decided in cycle N):
//      N+1: mem_ren=1, mem_raddr=addr[g] (registered), tag stage0=g, inflight[g]=1
//      N+2: mem_rdata valid; tag stage1=g
//      N+3: rdata=mem_rdata (registered), rdy[g]=1, inflight[g] cleared
//    Latency req->rdy = 3 cycles uncontended. Throughput 1 read/cycle across ports.
//  - mem_ren=0 and mem_raddr holds previous value in cycles with no grant.
//  - rdata holds its last value when rdy=0.
//  - Same port never has two reads in flight; port re-eligible the cycle after its rdy.
//  - Fairness: with all ports requesting, each port gets exactly one grant per
//    NUM_PORTS consecutive grants; worst-case wait NUM_PORTS-1 cycles + 3 latency.
//  - Pointer wrap: last=NUM_PORTS-1 -> search starts at 0.
//  - busy = |inflight.
//  - rst mid-operation: all in-flight reads discarded, no rdy pulse emitted for them,
//    state returns to reset values; requests still high after reset are re-arbitrated.
// CONFIGURATION
//  ARB_PORT0_PRIORITY_EN defined: port 0 wins whenever eligible, overriding round-robin;
//    port-0 grants do not move the pointer; ports 1..N-1 round-robin among themselves.
//  Not defined: pure round-robin over all ports as above.
// TESTING (BRAM model: mem[a] = a[7:0], 1-cycle registered read)
//  - Port 3 alone, addr 0x123 at cycle 0 -> rdy=0x08 at cycle 3, rdata=0x23; busy 1..3.
//  - All 8 req after reset, addr_i=0x10+i -> grants 0..7 on consecutive cycles; rdy
//    one-hot 0x01..0x80 on cycles 3..10, rdata 0x10..0x17.
//  - Ports 0 and 1 held high continuously -> alternating grants; each port one rdy
//    every 4 cycles max, never two reads in flight per port.
//  - Grants issued cycles 0,1 then rst pulsed cycle 2 -> no rdy ever seen for them;
//    all outputs 0 during reset; next request served with 3-cycle latency.
//  - ARB_PORT0_PRIORITY_EN, ports 0,2,5 continuous -> port 0 granted every cycle it is
//    eligible; 2 and 5 alternate in the remaining slots; without macro: 0,2,5,0,2,5.

Source files
------------

// File: rtl/strip_mem_arbiter_if.sv
// Bus between the strip drivers / frame BRAM read port and strip_mem_arbiter.
// The slave modport is the arbiter's view; master is the requester and BRAM side.
interface strip_mem_arbiter_if #(
  parameter int NUM_PORTS     = 8,
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 8
);
  logic [NUM_PORTS-1:0]               req;
  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]              rdata;
  logic [NUM_PORTS-1:0]               rdy;
  logic                               mem_ren;
  logic [ADDRESS_WIDTH-1:0]           mem_raddr;
  logic [DATA_WIDTH-1:0]              mem_rdata;
  logic                               busy;

  modport master (
    output req, addr, mem_rdata,
    input  rdata, rdy, mem_ren, mem_raddr, busy
  );

  modport slave (
    input  req, addr, mem_rdata,
    output rdata, rdy, mem_ren, mem_raddr, busy
  );
endinterface

// File: rtl/strip_mem_arbiter.sv
// Round-robin share of the frame BRAM read port; ARB_PORT0_PRIORITY_EN lets port 0 pre-empt.
// 3 cycles req->rdy, one read per cycle; requesters hold req/addr until their rdy pulse.
module strip_mem_arbiter #(
  parameter int NUM_PORTS     = 8,
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 8
) (
  input logic                clk,
  input logic                rst,
  strip_mem_arbiter_if.slave bus
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

`ifdef ARB_PORT0_PRIORITY_EN
  localparam bit PORT0_PRIO = 1'b1;
`else
  localparam bit PORT0_PRIO = 1'b0;
`endif

  logic [NUM_PORTS-1:0] inflight;
  logic [NUM_PORTS-1:0] eligible;
  logic [PW-1:0]        last_ptr;
  logic [PW-1:0]        grant_idx;
  logic [PW-1:0]        cand;
  logic                 grant_vld;
  logic [PW-1:0]        tag0;
  logic [PW-1:0]        tag1;
  logic                 vld0;
  logic                 vld1;

  // A port stays masked through its rdy cycle, so a req still high then is the old request.
  assign eligible = bus.req & ~inflight;
  assign bus.busy = |inflight;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (PORT0_PRIO && eligible[0]) begin
      grant_vld = 1'b1;
      grant_idx = '0;
    end
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = PW'((int'(last_ptr) + k) % NUM_PORTS);
      if (!grant_vld && eligible[cand] && !(PORT0_PRIO && cand == '0)) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ptr      <= PW'(NUM_PORTS - 1);
      inflight      <= '0;
      vld0          <= 1'b0;
      vld1          <= 1'b0;
      tag0          <= '0;
      tag1          <= '0;
      bus.mem_ren   <= 1'b0;
      bus.mem_raddr <= '0;
      bus.rdy       <= '0;
      bus.rdata     <= '0;
    end else begin
      bus.mem_ren <= grant_vld;
      if (grant_vld) begin
        bus.mem_raddr <= bus.addr[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        // Priority grants to port 0 leave the rotation of ports 1..N-1 undisturbed.
        if (!(PORT0_PRIO && grant_idx == '0))
          last_ptr <= grant_idx;
      end
      vld0 <= grant_vld;
      tag0 <= grant_idx;
      vld1 <= vld0;
      tag1 <= tag0;
      bus.rdy <= vld1 ? (NUM_PORTS'(1) << tag1) : '0;
      if (vld1)
        bus.rdata <= bus.mem_rdata;
      inflight <= (inflight & ~bus.rdy) |
                  (grant_vld ? (NUM_PORTS'(1) << grant_idx) : '0);
    end
  end
endmodule
